// File: rtl/dmem_pkg.sv
// Shared types and lane-steering helpers for the data-memory SRAM initiator.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_e;

  // Byte-lane write mask for a store of the given size at the given byte offset.
  function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] off);
    case (size)
      SZ_B:    lane_mask = 4'b0001 << off;
      SZ_H:    lane_mask = 4'b0011 << {off[1], 1'b0};
      SZ_W:    lane_mask = 4'hF;
      default: lane_mask = 4'h0;
    endcase
  endfunction

  // Right-aligned store data replicated across every lane it could land in.
  function automatic logic [31:0] lane_wdata(input size_e size, input logic [31:0] data);
    case (size)
      SZ_B:    lane_wdata = {4{data[7:0]}};
      SZ_H:    lane_wdata = {2{data[15:0]}};
      default: lane_wdata = data;
    endcase
  endfunction

  function automatic logic req_error(input size_e size, input logic [1:0] off);
    case (size)
      SZ_B:    req_error = 1'b0;
      SZ_H:    req_error = off[0];
      SZ_W:    req_error = (off != 2'b00);
      default: req_error = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Combinational load path: shifts the SRAM word down to the addressed lane,
// truncates to the access size and sign- or zero-extends.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rd_word >> {offset, 3'b000};
    data    = shifted;
    case (size)
      SZ_B:    data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      SZ_H:    data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_sram_initiator.sv
// LSU-facing initiator for the data SRAM: one decoupled request becomes one
// single-cycle SRAM access, followed by exactly one response.
module dmem_sram_initiator
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 13,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [31:0]           req_addr_i,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  csb_o,
  output logic                  web_o,
  output logic [3:0]            wmask_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic [DATA_WIDTH-1:0] rdata_i
);

  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

  state_e      state;
  logic [2:0]  lat_cnt;
  logic [1:0]  off_q;
  size_e       size_q;
  logic        uns_q;
  logic        we_q;
  size_e       req_size;
  logic [31:0] load_data;
  logic        unused_addr_bits;

  assign req_size         = size_e'(req_size_i);
  assign req_ready_o      = (state == IDLE);
  assign unused_addr_bits = ^req_addr_i[31:ADDR_WIDTH+2];

  dmem_load_align u_align (
    .rd_word     (rdata_i),
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (load_data)
  );

  // Offset/size/sign of the accepted request are latched so the response
  // never depends on the request bus after acceptance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      lat_cnt     <= 3'd0;
      off_q       <= 2'b00;
      size_q      <= SZ_B;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      csb_o       <= 1'b1;
      web_o       <= 1'b1;
      wmask_o     <= 4'h0;
      addr_o      <= '0;
      wdata_o     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= 32'h0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            off_q  <= req_addr_i[1:0];
            size_q <= req_size;
            uns_q  <= req_unsigned_i;
            we_q   <= req_we_i;
            if (req_error(req_size, req_addr_i[1:0])) begin
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= 32'h0;
              state       <= RESP;
            end else begin
              csb_o   <= 1'b0;
              web_o   <= ~req_we_i;
              wmask_o <= req_we_i ? lane_mask(req_size, req_addr_i[1:0]) : 4'h0;
              addr_o  <= req_addr_i[ADDR_WIDTH+1:2];
              if (req_we_i) begin
                wdata_o <= lane_wdata(req_size, req_wdata_i);
              end
              state <= ISSUE;
            end
          end
        end

        ISSUE: begin
          csb_o   <= 1'b1;
          web_o   <= 1'b1;
          wmask_o <= 4'h0;
          if (we_q) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= 32'h0;
            state       <= RESP;
          end else begin
            lat_cnt <= 3'd0;
            state   <= WAIT;
          end
        end

        // rdata_i becomes valid READ_LATENCY cycles after the sampling edge.
        WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= load_data;
            state       <= RESP;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_sram_initiator.sv
// Directed bench for dmem_sram_initiator against a behavioural SRAM with
// a three-cycle read latency.
module tb_dmem_sram_initiator;

  localparam int ADDR_WIDTH = 13;
  localparam int LAT        = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  logic [31:0]           req_addr = 32'h0;
  logic                  req_we = 1'b0;
  logic [1:0]            req_size = 2'b00;
  logic                  req_unsigned = 1'b0;
  logic [31:0]           req_wdata = 32'h0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  csb;
  logic                  web;
  logic [3:0]            wmask;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [31:0]           rdata;

  always #5 clk = ~clk;

  dmem_sram_initiator #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DATA_WIDTH   (32),
    .READ_LATENCY (LAT)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_addr_i     (req_addr),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .csb_o          (csb),
    .web_o          (web),
    .wmask_o        (wmask),
    .addr_o         (addr),
    .wdata_o        (wdata),
    .rdata_i        (rdata)
  );

  // Behavioural SRAM; idle read slots carry a poison word so a mistimed capture shows up.
  bit   [31:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [31:0] rd_pipe [0:LAT-1];
  int          csb_low_count = 0;

  always @(posedge clk) begin
    if (!csb && !web) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rd_pipe[0] <= (!csb && web) ? mem[addr] : 32'hBAD0BAD0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign rdata = rd_pipe[LAT-1];

  always @(posedge clk) begin
    if (!csb) csb_low_count++;
  end

  int checks = 0;
  int errors = 0;

  logic        issue_csb;
  logic        issue_web;
  logic [3:0]  issue_mask;
  logic [31:0] issue_addr;
  logic [31:0] issue_wdata;
  logic        issue_ready;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Runs one request end to end; the ISSUE-cycle SRAM outputs are left in issue_* for the caller.
  task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] a, input logic [31:0] d,
                               input int hold, input logic [31:0] exp_data,
                               input logic exp_err, input int exp_cycles);
    int n;
    int start_cnt;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
    start_cnt    = csb_low_count;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = d;
    rsp_ready    = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid   = 1'b0;
    issue_csb   = csb;
    issue_web   = web;
    issue_mask  = wmask;
    issue_addr  = 32'(addr);
    issue_wdata = wdata;
    issue_ready = req_ready;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({tag, "_latency"}, 32'(n), 32'(exp_cycles));
    checkOutput({tag, "_rdata"}, rsp_rdata, exp_data);
    checkOutput({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    checkOutput({tag, "_resp_ready"}, 32'(req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      checkOutput({tag, "_hold_rdata"}, rsp_rdata, exp_data);
      checkOutput({tag, "_hold_err"}, 32'(rsp_err), 32'(exp_err));
      checkOutput({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_done_ready"}, 32'(req_ready), 32'd1);
    checkOutput({tag, "_csb_pulses"}, 32'(csb_low_count - start_cnt), exp_err ? 32'd0 : 32'd1);
  endtask

  initial begin
    int seen;

    repeat (2) @(negedge clk);
    checkOutput("rst_csb", 32'(csb), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_web", 32'(web), 32'd1);
    checkOutput("rst_wmask", 32'(wmask), 32'd0);
    checkOutput("rst_addr", 32'(addr), 32'd0);
    checkOutput("rst_wdata", wdata, 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);

    applyStimulus("st_w", 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 2);
    checkOutput("st_w_csb", 32'(issue_csb), 32'd0);
    checkOutput("st_w_web", 32'(issue_web), 32'd0);
    checkOutput("st_w_addr", issue_addr, 32'd4);
    checkOutput("st_w_mask", 32'(issue_mask), 32'hF);
    checkOutput("st_w_wdata", issue_wdata, 32'hDEAD_BEEF);
    checkOutput("st_w_issue_ready", 32'(issue_ready), 32'd0);

    applyStimulus("st_b", 1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'hFFFF_FFA5, 0, 32'h0, 1'b0, 2);
    checkOutput("st_b_mask", 32'(issue_mask), 32'h8);
    checkOutput("st_b_wdata", issue_wdata, 32'hA5A5_A5A5);
    checkOutput("st_b_addr", issue_addr, 32'd4);

    applyStimulus("ld_w", 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 0, 32'hA5AD_BEEF, 1'b0, 2 + LAT);
    checkOutput("ld_w_csb", 32'(issue_csb), 32'd0);
    checkOutput("ld_w_web", 32'(issue_web), 32'd1);
    checkOutput("ld_w_mask", 32'(issue_mask), 32'd0);

    applyStimulus("ld_bs", 1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0, 0, 32'hFFFF_FFA5, 1'b0, 2 + LAT);
    applyStimulus("ld_bu", 1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, 0, 32'h0000_00A5, 1'b0, 2 + LAT);
    applyStimulus("ld_hs", 1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0, 0, 32'hFFFF_A5AD, 1'b0, 2 + LAT);
    applyStimulus("ld_hu", 1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0, 0, 32'h0000_BEEF, 1'b0, 2 + LAT);
    applyStimulus("ld_b1", 1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0, 0, 32'hFFFF_FFBE, 1'b0, 2 + LAT);

    applyStimulus("st_h", 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'hCAFE_1234, 0, 32'h0, 1'b0, 2);
    checkOutput("st_h_mask", 32'(issue_mask), 32'hC);
    checkOutput("st_h_wdata", issue_wdata, 32'h1234_1234);
    checkOutput("st_h_addr", issue_addr, 32'd8);
    applyStimulus("ld_w20", 1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 0, 32'h1234_0000, 1'b0, 2 + LAT);

    applyStimulus("err_w", 1'b0, 2'b10, 1'b0, 32'h0000_0012, 32'h0, 0, 32'h0, 1'b1, 1);
    checkOutput("err_w_csb", 32'(issue_csb), 32'd1);
    applyStimulus("err_sz", 1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h0, 1'b1, 1);
    applyStimulus("err_st_h", 1'b1, 2'b01, 1'b0, 32'h0000_0011, 32'h0000_FFFF, 0, 32'h0, 1'b1, 1);
    applyStimulus("ld_after_err", 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 0, 32'hA5AD_BEEF, 1'b0, 2 + LAT);

    applyStimulus("st_alias", 1'b1, 2'b10, 1'b0, 32'h0000_8000, 32'h55AA_55AA, 0, 32'h0, 1'b0, 2);
    checkOutput("st_alias_addr", issue_addr, 32'd0);
    applyStimulus("ld_alias", 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 0, 32'h55AA_55AA, 1'b0, 2 + LAT);

    applyStimulus("bp", 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 5, 32'hA5AD_BEEF, 1'b0, 2 + LAT);

    // Reset while the load is waiting on the SRAM must drop it silently.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 2'b10;
    req_addr  = 32'h0000_0010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_wait_csb", 32'(csb), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_wait_req_ready", 32'(req_ready), 32'd1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checkOutput("rst_wait_no_rsp", 32'(seen), 32'd0);
    applyStimulus("ld_post_rst", 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 0, 32'hA5AD_BEEF, 1'b0, 2 + LAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
